// File: rtl/bus_rx_latch.sv
// rtl/bus_rx_latch.sv - gated word bus receiver with small FIFO and valid/ready output
// Optional feature macro: BUS_PARITY_EN (adds bus_p input and sticky perr output)
module bus_rx_latch #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         bus_d,
    input  logic                     bus_en,
`ifdef BUS_PARITY_EN
    input  logic                     bus_p,
`endif
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_y,
    output logic                     bus_busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
`ifdef BUS_PARITY_EN
    ,
    output logic                     perr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    logic word_ok;
    logic word_bad;
    logic do_read;
    logic do_write;
    logic drop_full;

`ifdef BUS_PARITY_EN
    // Even parity over data plus parity bit; a bad word is rejected before the full check
    always_comb begin
        word_ok  = bus_en & ~(^{bus_d, bus_p});
        word_bad = bus_en &  (^{bus_d, bus_p});
    end
`else
    // Every enabled word is a candidate for storage
    always_comb begin
        word_ok  = bus_en;
        word_bad = 1'b0;
    end
`endif

    // Handshake qualifiers; a read on the same edge frees the slot for a write while full
    always_comb begin
        do_read   = out_valid & out_ready;
        do_write  = word_ok & (~bus_busy | do_read);
        drop_full = word_ok & bus_busy & ~do_read;
    end

    // Head word is masked so the consumer never sees stale storage
    always_comb begin
        out_y = mem[rd_ptr] & {WIDTH{out_valid}};
    end

    // Storage array; contents need no reset because the head is masked by out_valid
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wr_ptr] <= bus_d;
        end
    end

    // Occupancy state machine with pointers, registered flags and sticky error bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            bus_busy  <= 1'b0;
            ovf       <= 1'b0;
`ifdef BUS_PARITY_EN
            perr      <= 1'b0;
`endif
        end else begin
            if (do_read) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (drop_full) begin
                ovf <= 1'b1;
            end
`ifdef BUS_PARITY_EN
            if (word_bad) begin
                perr <= 1'b1;
            end
`else
            if (word_bad) begin
                ovf <= ovf;
            end
`endif
            case (state)
                ST_EMPTY: begin
                    if (do_write) begin
                        count     <= ONE_CNT;
                        out_valid <= 1'b1;
                        if (FULL_CNT == ONE_CNT) begin
                            state    <= ST_FULL;
                            bus_busy <= 1'b1;
                        end else begin
                            state <= ST_PARTIAL;
                        end
                    end
                end
                ST_PARTIAL: begin
                    if (do_write && !do_read) begin
                        count <= count + ONE_CNT;
                        if (count == FULL_CNT - ONE_CNT) begin
                            state    <= ST_FULL;
                            bus_busy <= 1'b1;
                        end
                    end else if (do_read && !do_write) begin
                        count <= count - ONE_CNT;
                        if (count == ONE_CNT) begin
                            state     <= ST_EMPTY;
                            out_valid <= 1'b0;
                        end
                    end
                end
                ST_FULL: begin
                    if (do_read && !do_write) begin
                        count    <= count - ONE_CNT;
                        bus_busy <= 1'b0;
                        if (count == ONE_CNT) begin
                            state     <= ST_EMPTY;
                            out_valid <= 1'b0;
                        end else begin
                            state <= ST_PARTIAL;
                        end
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    count     <= '0;
                    out_valid <= 1'b0;
                    bus_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rx_latch.sv
// tb/tb_bus_rx_latch.sv - randomized and directed self-checking bench for bus_rx_latch
module tb_bus_rx_latch;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] bus_d = '0;
    logic             bus_en = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_y;
    logic             bus_busy;
    logic [CW-1:0]    count;
    logic             ovf;
`ifdef BUS_PARITY_EN
    logic             bus_p = 1'b0;
    logic             perr;
    logic             bad_par = 1'b0;
    logic             m_perr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq[$];
    logic             m_ovf = 1'b0;
    logic             live = 1'b0;

    bus_rx_latch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_d     (bus_d),
        .bus_en    (bus_en),
`ifdef BUS_PARITY_EN
        .bus_p     (bus_p),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_y     (out_y),
        .bus_busy  (bus_busy),
        .count     (count),
        .ovf       (ovf)
`ifdef BUS_PARITY_EN
        ,
        .perr      (perr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of stored words plus sticky flags, advanced on each rising edge
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
`ifdef BUS_PARITY_EN
            m_perr = 1'b0;
`endif
            live = 1'b1;
        end else if (live) begin
            logic ok;
            ok = bus_en;
`ifdef BUS_PARITY_EN
            if (bus_en && (^{bus_d, bus_p})) begin
                ok = 1'b0;
                m_perr = 1'b1;
            end
`endif
            if (mq.size() > 0 && out_ready) begin
                void'(mq.pop_front());
            end
            if (ok) begin
                if (mq.size() < DEPTH) mq.push_back(bus_d);
                else m_ovf = 1'b1;
            end
        end
    end

    // Compare every output against the reference away from the active edge
    always @(negedge clk) begin
        if (live) begin
            check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("out_y", 32'(out_y), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            check("count", 32'(count), 32'(mq.size()));
            check("bus_busy", 32'(bus_busy), 32'(mq.size() == DEPTH));
            check("ovf", 32'(ovf), 32'(m_ovf));
`ifdef BUS_PARITY_EN
            check("perr", 32'(perr), 32'(m_perr));
`endif
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [WIDTH-1:0] d, input logic rd);
        rst       = r;
        bus_en    = e;
        bus_d     = d;
        out_ready = rd;
`ifdef BUS_PARITY_EN
        bus_p     = (^d) ^ bad_par;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: single word latency and drain
        cyc(1, 0, '0, 0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_busy", 32'(bus_busy), 32'h0);
        cyc(0, 1, 16'hA5A5, 0);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_y", 32'(out_y), 32'hA5A5);
        check("t1_count", 32'(count), 32'h1);
        cyc(0, 0, '0, 1);
        check("t1_drain_valid", 32'(out_valid), 32'h0);
        check("t1_drain_y", 32'(out_y), 32'h0);

        // 2: data ignored while enable is low
        for (int i = 0; i < 5; i++) cyc(0, 0, 16'hFFFF, 0);
        check("t2_count", 32'(count), 32'h0);
        check("t2_y", 32'(out_y), 32'h0);
        check("t2_ovf", 32'(ovf), 32'h0);

        // 3: overflow drops the third word
        cyc(0, 1, 16'h0001, 0);
        check("t3_busy1", 32'(bus_busy), 32'h0);
        cyc(0, 1, 16'h0002, 0);
        check("t3_busy2", 32'(bus_busy), 32'h1);
        cyc(0, 1, 16'h0003, 0);
        check("t3_ovf", 32'(ovf), 32'h1);
        check("t3_count", 32'(count), 32'h2);
        check("t3_head1", 32'(out_y), 32'h0001);
        cyc(0, 0, '0, 1);
        check("t3_head2", 32'(out_y), 32'h0002);
        cyc(0, 0, '0, 1);
        check("t3_empty", 32'(out_valid), 32'h0);

        // 4: simultaneous read and write while full
        cyc(1, 0, '0, 0);
        cyc(0, 1, 16'h0011, 0);
        cyc(0, 1, 16'h0022, 0);
        cyc(0, 1, 16'h0033, 1);
        check("t4_count", 32'(count), 32'h2);
        check("t4_ovf", 32'(ovf), 32'h0);
        check("t4_head1", 32'(out_y), 32'h0022);
        cyc(0, 0, '0, 1);
        check("t4_head2", 32'(out_y), 32'h0033);
        cyc(0, 0, '0, 1);
        check("t4_empty", 32'(count), 32'h0);

        // 5: reset wins over a same-edge write
        cyc(0, 1, 16'h0001, 0);
        cyc(0, 1, 16'h0002, 0);
        cyc(0, 1, 16'h0003, 0);
        check("t5_pre_ovf", 32'(ovf), 32'h1);
        cyc(1, 1, 16'h0044, 0);
        check("t5_count", 32'(count), 32'h0);
        check("t5_ovf", 32'(ovf), 32'h0);
        check("t5_valid", 32'(out_valid), 32'h0);
        check("t5_busy", 32'(bus_busy), 32'h0);
        cyc(0, 0, '0, 0);
        check("t5_not_stored", 32'(out_valid), 32'h0);

`ifdef BUS_PARITY_EN
        // 6: parity rejection
        bad_par = 1'b1;
        cyc(0, 1, 16'h0001, 0);
        bad_par = 1'b0;
        check("t6_perr", 32'(perr), 32'h1);
        check("t6_count", 32'(count), 32'h0);
        cyc(0, 1, 16'h0001, 0);
        check("t6_y", 32'(out_y), 32'h0001);
        cyc(1, 0, '0, 0);
`endif

        // 7: random traffic against the reference queue
        for (int blk = 0; blk < 20; blk++) begin
            int rd_pct;
            rd_pct = int'($urandom_range(10, 90));
            for (int i = 0; i < 500; i++) begin
                logic r, e, rd;
                r  = ($urandom_range(0, 999) == 0);
                e  = ($urandom_range(0, 99) < 60);
                rd = (int'($urandom_range(0, 99)) < rd_pct);
`ifdef BUS_PARITY_EN
                bad_par = ($urandom_range(0, 19) == 0);
`endif
                cyc(r, e, WIDTH'($urandom), rd);
            end
        end
        cyc(0, 0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
